out_bram_reader: RTL and testbench

//   Drains SNN output samples from the output BRAM, reading from the same word-address

---
 rtl/out_bram_reader.sv | 150 +++++++++++++++
 tb/tb_out_bram_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_bram_reader.sv
// Output BRAM drain: chases the output writer's address pointer and streams each word out on
// a valid/ready port. Define OUT_RD_LAST_EN to add the frame counter that drives m_last.
module out_bram_reader #(
  parameter logic [31:0] BRAM_MAX_ADDR = 32'h0000_2000,
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned FRAME_WORDS   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wr_addr,
  input  logic        flush,
  output logic        bram_en,
  output logic [31:0] bram_addr,
  input  logic [31:0] bram_dout,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [31:0] rd_addr,
  output logic        empty
);

  if (RD_LATENCY < 1 || RD_LATENCY > 3 || FRAME_WORDS < 1) begin : g_bad_param
    $error("out_bram_reader: RD_LATENCY must be 1..3 and FRAME_WORDS at least 1");
  end

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sync1_q, sync2_q, sync3_q;
  logic [31:0] wr_stable_q, wr_stable_d;

  // Same address step as the writer; BRAM_MAX_ADDR itself is a legal slot.
  function automatic logic [31:0] addr_step(input logic [31:0] a);
    return (a < BRAM_MAX_ADDR - 32'd1) ? a + 32'd4 : 32'd0;
  endfunction

  // Pointer only moves after two equal samples so a skewed multi-bit change is never used.
  assign wr_stable_d = (sync2_q == sync3_q) ? sync2_q : wr_stable_q;
  assign empty       = (rd_addr_q == wr_stable_q);

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    cnt_d     = cnt_q;
    bram_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (flush) begin
          rd_addr_d = wr_stable_q;
        end else if (!empty) begin
          bram_en = 1'b1;
          cnt_d   = 2'(RD_LATENCY);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 2'd1) begin
          m_data_d  = bram_dout;
          m_valid_d = 1'b1;
          rd_addr_d = addr_step(rd_addr_q);
          state_d   = StHold;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StHold: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_addr_q   <= 32'd0;
      m_data_q    <= 32'd0;
      m_valid_q   <= 1'b0;
      cnt_q       <= 2'd0;
      sync1_q     <= 32'd0;
      sync2_q     <= 32'd0;
      sync3_q     <= 32'd0;
      wr_stable_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      cnt_q       <= cnt_d;
      sync1_q     <= wr_addr;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      wr_stable_q <= wr_stable_d;
    end
  end

`ifdef OUT_RD_LAST_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        m_last_q, m_last_d;
  logic        frame_end;

  // m_last is decided at capture time so it is stable for the whole hold.
  assign frame_end = (frame_cnt_q == 16'(FRAME_WORDS - 1));

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    m_last_d    = m_last_q;
    if (state_q == StIdle && flush) begin
      frame_cnt_d = 16'd0;
    end
    if (state_q == StWait && cnt_q == 2'd1) begin
      m_last_d = frame_end;
    end
    if (state_q == StHold && m_ready) begin
      m_last_d    = 1'b0;
      frame_cnt_d = frame_end ? 16'd0 : frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
      m_last_q    <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      m_last_q    <= m_last_d;
    end
  end

  assign m_last = m_last_q;
`else
  assign m_last = 1'b0;
`endif

  assign bram_addr = rd_addr_q;
  assign rd_addr   = rd_addr_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;

endmodule

// File: tb/tb_out_bram_reader.sv
// Randomized bench for out_bram_reader: a queue of addresses the writer has published is the
// reference; every read and every accepted word is checked against it.
module tb_out_bram_reader;

  localparam int unsigned RdLat      = 1;
  localparam int unsigned FrameWords = 4;
  localparam logic [31:0] MaxAddr    = 32'h0000_2000;
  localparam logic [31:0] Key        = 32'h0000_A5A5;
`ifdef OUT_RD_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wr_addr;
  logic        flush;
  logic        bram_en;
  logic [31:0] bram_addr;
  logic [31:0] bram_dout;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [31:0] rd_addr;
  logic        empty;

  out_bram_reader #(
    .BRAM_MAX_ADDR(MaxAddr),
    .RD_LATENCY   (RdLat),
    .FRAME_WORDS  (FrameWords)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .bram_en  (bram_en),
    .bram_addr(bram_addr),
    .bram_dout(bram_dout),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .rd_addr  (rd_addr),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // BRAM content is addr ^ Key; data appears RdLat cycles after the enable.
  logic [31:0] pipe [RdLat];
  always @(posedge clk) begin
    pipe[0] <= bram_en ? (bram_addr ^ Key) : 32'hDEAD_BEEF;
    for (int i = 1; i < int'(RdLat); i++) pipe[i] <= pipe[i-1];
  end
  assign bram_dout = pipe[RdLat-1];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          got_last[$];
  int          acc = 0;
  logic [31:0] wr = 32'd0;

  function automatic logic [31:0] nxt(input logic [31:0] a);
    return (a < MaxAddr - 32'd1) ? a + 32'd4 : 32'd0;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the address queue.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    logic [31:0] a;
    logic        el;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk1("hold_valid", m_valid, 1'b1);
        chk32("hold_data", m_data, prev_data);
        chk1("hold_last", m_last, prev_last);
      end
      if (bram_en) begin
        chk1("one_in_flight", m_valid, 1'b0);
        if (exp_q.size() == 0) chk1("spurious_read", bram_en, 1'b0);
        else chk32("read_addr", bram_addr, exp_q[0]);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk1("spurious_word", m_valid, 1'b0);
        end else begin
          a  = exp_q.pop_front();
          el = LastEn && (((acc + 1) % int'(FrameWords)) == 0);
          chk32("word_data", m_data, a ^ Key);
          chk1("word_last", m_last, el);
          acc = el ? 0 : acc + 1;
          got_q.push_back(m_data);
          got_last.push_back(m_last);
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic advance(input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(wr);
      wr = nxt(wr);
    end
    wr_addr = wr;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && empty && !m_valid) done = 1'b1;
    end
    chk1("drain_done", done, 1'b1);
    cycles(1);
  endtask

  task automatic wait_valid(input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (m_valid) done = 1'b1;
    end
    chk1("wait_valid", done, 1'b1);
    cycles(1);
  endtask

  // Reader must be idle and drained; flush held long enough for the pointer to settle.
  task automatic flush_to(input logic [31:0] a);
    flush   = 1'b1;
    wr      = a;
    wr_addr = a;
    cycles(10);
    flush = 1'b0;
    acc   = 0;
    cycles(1);
  endtask

  task automatic reset_mid_hold();
    m_ready = 1'b0;
    advance(2);
    wait_valid(50);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk1("rst_valid", m_valid, 1'b0);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_bram_en", bram_en, 1'b0);
    chk32("rst_rd_addr", rd_addr, 32'd0);
    exp_q.delete();
    wr      = 32'd0;
    wr_addr = 32'd0;
    acc     = 0;
    cycles(2);
    reset = 1'b0;
    cycles(1);
  endtask

  initial begin
    logic [7:0] mask;
    bit         seen;
    reset   = 1'b1;
    wr_addr = 32'd0;
    flush   = 1'b0;
    m_ready = 1'b0;
    #1;
    chk32("reset_rd_addr", rd_addr, 32'd0);
    chk32("reset_m_data", m_data, 32'd0);
    chk1("reset_m_valid", m_valid, 1'b0);
    chk1("reset_empty", empty, 1'b1);
    chk1("reset_bram_en", bram_en, 1'b0);
    cycles(3);
    reset = 1'b0;

    // Idle with nothing written
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("idle_empty", empty, 1'b1);
      chk1("idle_valid", m_valid, 1'b0);
    end
    cycles(1);

    // Three words in order
    m_ready = 1'b1;
    advance(3);
    drain(100);
    chk32("t2_count", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      chk32("t2_w0", got_q[0], 32'h0000_A5A5);
      chk32("t2_w1", got_q[1], 32'h0000_A5A1);
      chk32("t2_w2", got_q[2], 32'h0000_A5AD);
    end
    chk32("t2_rd_addr", rd_addr, 32'h0000_000C);
    chk1("t2_empty", empty, 1'b1);

    // Backpressure for ten cycles, then release
    m_ready = 1'b0;
    advance(3);
    wait_valid(50);
    cycles(10);
    chk1("t4_valid", m_valid, 1'b1);
    chk32("t4_data", m_data, 32'h0000_A5A9);
    m_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bram_en) seen = 1'b1;
    end
    chk1("t4_next_read", seen, 1'b1);
    drain(100);

    // Flush five unread words
    reset = 1'b1;
    exp_q.delete();
    wr      = 32'd0;
    wr_addr = 32'd0;
    acc     = 0;
    cycles(2);
    reset = 1'b0;
    cycles(2);
    flush = 1'b1;
    for (int k = 0; k < 5; k++) wr = nxt(wr);
    wr_addr = wr;
    cycles(10);
    flush = 1'b0;
    cycles(5);
    chk32("t5_rd_addr", rd_addr, 32'h0000_0014);
    chk1("t5_empty", empty, 1'b1);
    chk1("t5_valid", m_valid, 1'b0);

    // Wrap through the 0x2000 slot
    flush_to(32'h0000_1FFC);
    got_q.delete();
    advance(1);
    cycles(8);
    advance(2);
    drain(100);
    chk32("t3_count", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      chk32("t3_w0", got_q[0], 32'h0000_BA59);
      chk32("t3_w1", got_q[1], 32'h0000_85A5);
      chk32("t3_w2", got_q[2], 32'h0000_A5A5);
    end
    chk32("t3_rd_addr", rd_addr, 32'h0000_0004);

    // Random writer steps and backpressure across the wrap
    flush_to(32'h0000_1F80);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0 && exp_q.size() < 40) advance(int'($urandom_range(3, 1)));
      m_ready = ($urandom_range(2) != 0);
      cycles(1);
    end
    m_ready = 1'b1;
    drain(1000);
    chk32("rand_rd_addr", rd_addr, wr);
    chk1("rand_empty", empty, 1'b1);

    reset_mid_hold();

`ifdef OUT_RD_LAST_EN
    got_q.delete();
    got_last.delete();
    m_ready = 1'b1;
    advance(8);
    drain(200);
    mask = 8'd0;
    for (int i = 0; i < 8 && i < got_last.size(); i++) mask[i] = got_last[i];
    chk32("t6_last_mask", {24'd0, mask}, 32'h0000_0088);
    reset_mid_hold();
    got_last.delete();
    m_ready = 1'b1;
    advance(4);
    drain(200);
    mask = 8'd0;
    for (int i = 0; i < 8 && i < got_last.size(); i++) mask[i] = got_last[i];
    chk32("t6_last_after_reset", {24'd0, mask}, 32'h0000_0008);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
